slave_arbiter: RTL and testbench

SLAVE_ARBITER -- requirements
Module: slave_arbiter

---
 rtl/slave_arbiter.sv | 143 ++++++++++++++
 tb/tb_slave_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/slave_arbiter.sv
// Round-robin AHB slave-port arbiter with burst and lock tracking.
// Ports: i_clk/i_rst, per-master i_req/i_htrans/i_hburst/i_hmastlock,
// slave i_hready; o_bus_grant/o_data_sel one-hot, o_master_id, o_master_wait.
module slave_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_WIDTH    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_MASTERS-1:0]   i_req,
  input  logic [2*NUM_MASTERS-1:0] i_htrans,
  input  logic [3*NUM_MASTERS-1:0] i_hburst,
  input  logic [NUM_MASTERS-1:0]   i_hmastlock,
  input  logic                     i_hready,
  output logic [NUM_MASTERS-1:0]   o_bus_grant,
  output logic [NUM_MASTERS-1:0]   o_data_sel,
  output logic [ID_WIDTH-1:0]      o_master_id,
  output logic [NUM_MASTERS-1:0]   o_master_wait
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_BURST,
    S_LOCKED
  } state_t;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  state_t                   state_q, state_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [NUM_MASTERS-1:0]   dsel_q;
  logic [4:0]               cnt_q, cnt_d;
  logic                     undef_q, undef_d;

  logic [1:0]               own_tr;
  logic                     own_lock;
  logic                     tr_seq, tr_end;
  logic                     arb;
  logic                     win_found;
  logic [ID_WIDTH-1:0]      win_id;
  logic [2:0]               win_burst;
  logic                     win_lock;

  assign own_tr   = i_htrans[2*int'(id_q) +: 2];
  assign own_lock = i_hmastlock[id_q];
  assign tr_seq   = (own_tr == TR_SEQ);
  assign tr_end   = (own_tr == TR_IDLE) || (own_tr == TR_NSEQ);

  // Scan from farthest to nearest so the nearest requester after the
  // owner is the last assignment; the owner itself is the last resort.
  always_comb begin
    win_found = 1'b0;
    win_id    = id_q;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (i_req[(int'(id_q) + k) % NUM_MASTERS]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'((int'(id_q) + k) % NUM_MASTERS);
      end
    end
  end

  assign win_burst = i_hburst[3*int'(win_id) +: 3];
  assign win_lock  = i_hmastlock[win_id];

  always_comb begin
    arb = 1'b0;
    unique case (state_q)
      S_IDLE,
      S_SINGLE: arb = i_hready;
      S_BURST:  arb = i_hready &&
                      (tr_end || (!undef_q && tr_seq && cnt_q == 5'd0));
      S_LOCKED: arb = i_hready && !own_lock && own_tr == TR_IDLE;
      default:  arb = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      grant_q <= NUM_MASTERS'(1);
      dsel_q  <= NUM_MASTERS'(1);
      cnt_q   <= '0;
      undef_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      undef_q <= undef_d;
      if (i_hready) dsel_q <= grant_q;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    undef_d = undef_q;
    if (arb) begin
      cnt_d   = '0;
      undef_d = 1'b0;
      if (!win_found) begin
        state_d = S_IDLE;
      end else begin
        id_d = win_id;
        if (win_lock) begin
          state_d = S_LOCKED;
        end else begin
          state_d = S_BURST;
          unique case (1'b1)
            win_burst == 3'b000: state_d = S_SINGLE;
            win_burst == 3'b001: undef_d = 1'b1;
            win_burst[2:1] == 2'b01: cnt_d = 5'd3;
            win_burst[2:1] == 2'b10: cnt_d = 5'd7;
            win_burst[2:1] == 2'b11: cnt_d = 5'd15;
            default: state_d = S_SINGLE;
          endcase
        end
      end
    end else if (state_q == S_BURST && !undef_q &&
                 i_hready && tr_seq) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_comb begin
    grant_d       = '0;
    grant_d[id_d] = 1'b1;
  end

  always_comb begin
    o_bus_grant   = grant_q;
    o_data_sel    = dsel_q;
    o_master_id   = id_q;
    o_master_wait = i_req & ~grant_q;
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Bench for slave_arbiter: directed vector table, reset-abandon sequence,
// then random traffic against a transfer-level reference model.
module tb_slave_arbiter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [3:0]   htrans;
  logic [5:0]   hburst;
  logic [1:0]   hlock;
  logic         rdy;
  logic [1:0]   grant;
  logic [1:0]   dsel;
  logic [0:0]   mid;
  logic [1:0]   mwait;

  int n_cmp  = 0;
  int n_fail = 0;

  slave_arbiter #(.NUM_MASTERS(2), .ID_WIDTH(1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_htrans     (htrans),
    .i_hburst     (hburst),
    .i_hmastlock  (hlock),
    .i_hready     (rdy),
    .o_bus_grant  (grant),
    .o_data_sel   (dsel),
    .o_master_id  (mid),
    .o_master_wait(mwait)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner, data-phase owner, mode
  // (0 open/single, 1 fixed burst, 2 incr, 3 locked), beats left.
  int         m_owner, m_dsel, m_mode, m_left, m_w;
  logic [1:0] m_tr;
  logic [2:0] m_hb;
  logic       m_arb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_dsel = 0; m_mode = 0; m_left = 0;
    end else begin
      m_tr  = htrans[2*m_owner +: 2];
      m_arb = 1'b0;
      if (rdy) begin
        case (m_mode)
          0: m_arb = 1'b1;
          1: begin
            if (m_tr == 2'b11) begin
              if (m_left == 0) m_arb = 1'b1;
              else m_left = m_left - 1;
            end else if (m_tr != 2'b01) m_arb = 1'b1;
          end
          2: m_arb = (m_tr == 2'b00 || m_tr == 2'b10);
          default: m_arb = !hlock[m_owner] && m_tr == 2'b00;
        endcase
        m_dsel = m_owner;
      end
      if (m_arb) begin
        m_w = -1;
        for (int k = 1; k <= N; k++)
          if (m_w < 0 && req[(m_owner + k) % N]) m_w = (m_owner + k) % N;
        if (m_w < 0) m_mode = 0;
        else begin
          m_owner = m_w;
          m_hb = hburst[3*m_w +: 3];
          if (hlock[m_w]) m_mode = 3;
          else if (m_hb == 3'd0) m_mode = 0;
          else if (m_hb == 3'd1) m_mode = 2;
          else begin
            m_mode = 1;
            m_left = (4 << ((int'(m_hb) >> 1) - 1)) - 1;
          end
        end
      end
    end
  end

  typedef struct {
    logic [1:0] req;
    logic [3:0] tr;
    logic [5:0] hb;
    logic [1:0] lk;
    logic       rdy;
    logic [1:0] g;
    logic [1:0] ds;
    logic [1:0] w;
  } vec_t;

  vec_t tv[23];

  initial begin
    // single grant to master 1, then park
    tv[0]  = '{2'b10, 4'b1000, 6'o00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b00};
    tv[1]  = '{2'b00, 4'b0000, 6'o00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b00};
    // alternation with both requesting singles
    tv[2]  = '{2'b11, 4'b1010, 6'o00, 2'b00, 1'b1, 2'b01, 2'b10, 2'b10};
    tv[3]  = '{2'b11, 4'b1010, 6'o00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b01};
    tv[4]  = '{2'b11, 4'b1010, 6'o00, 2'b00, 1'b1, 2'b01, 2'b10, 2'b10};
    tv[5]  = '{2'b11, 4'b1010, 6'o00, 2'b00, 1'b1, 2'b10, 2'b01, 2'b01};
    // master 0 INCR4 with two wait states
    tv[6]  = '{2'b01, 4'b0010, 6'o03, 2'b00, 1'b1, 2'b01, 2'b10, 2'b00};
    tv[7]  = '{2'b11, 4'b1011, 6'o03, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10};
    tv[8]  = '{2'b11, 4'b1011, 6'o03, 2'b00, 1'b0, 2'b01, 2'b01, 2'b10};
    tv[9]  = '{2'b11, 4'b1011, 6'o03, 2'b00, 1'b0, 2'b01, 2'b01, 2'b10};
    tv[10] = '{2'b11, 4'b1011, 6'o03, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10};
    tv[11] = '{2'b11, 4'b1011, 6'o03, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10};
    tv[12] = '{2'b11, 4'b1011, 6'o03, 2'b00, 1'b1, 2'b10, 2'b01, 2'b01};
    // master 1 locked for three singles
    tv[13] = '{2'b10, 4'b1000, 6'o00, 2'b10, 1'b1, 2'b10, 2'b10, 2'b00};
    tv[14] = '{2'b11, 4'b1010, 6'o00, 2'b10, 1'b1, 2'b10, 2'b10, 2'b01};
    tv[15] = '{2'b11, 4'b1010, 6'o00, 2'b10, 1'b1, 2'b10, 2'b10, 2'b01};
    tv[16] = '{2'b11, 4'b1010, 6'o00, 2'b10, 1'b1, 2'b10, 2'b10, 2'b01};
    tv[17] = '{2'b01, 4'b0010, 6'o00, 2'b00, 1'b1, 2'b01, 2'b10, 2'b00};
    // master 0 INCR8 cut short by NONSEQ after 3 beats
    tv[18] = '{2'b01, 4'b0010, 6'o05, 2'b00, 1'b1, 2'b01, 2'b01, 2'b00};
    tv[19] = '{2'b11, 4'b1011, 6'o05, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10};
    tv[20] = '{2'b11, 4'b1011, 6'o05, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10};
    tv[21] = '{2'b11, 4'b1011, 6'o05, 2'b00, 1'b1, 2'b01, 2'b01, 2'b10};
    tv[22] = '{2'b11, 4'b1010, 6'o05, 2'b00, 1'b1, 2'b10, 2'b01, 2'b01};

    rst = 1'b1; req = '0; htrans = '0; hburst = '0; hlock = '0; rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 1);
    check("rst_dsel", dsel, 1);
    check("rst_id", mid, 0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      req = tv[i].req; htrans = tv[i].tr; hburst = tv[i].hb;
      hlock = tv[i].lk; rdy = tv[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), grant, tv[i].g);
      check($sformatf("vec%0d_dsel", i), dsel, tv[i].ds);
      check($sformatf("vec%0d_wait", i), mwait, tv[i].w);
      check($sformatf("vec%0d_id", i), mid, int'(tv[i].g[1]));
    end

    // master 1 INCR16, then reset mid-burst without a clock edge
    req = 2'b10; htrans = 4'b1000; hburst = 6'o70; hlock = '0; rdy = 1'b1;
    @(negedge clk);
    check("incr16_grant", grant, 2);
    htrans = 4'b1100;
    repeat (2) @(negedge clk);
    check("incr16_hold", grant, 2);
    #2 rst = 1'b1;
    #1;
    check("async_grant", grant, 1);
    check("async_dsel", dsel, 1);
    check("async_id", mid, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 800; i++) begin
      req    = 2'($urandom);
      htrans = 4'($urandom);
      hburst = 6'($urandom);
      hlock  = {($urandom % 8 == 0), ($urandom % 8 == 0)};
      rdy    = ($urandom % 4 != 0);
      @(negedge clk);
      check("rnd_grant", grant, 1 << m_owner);
      check("rnd_id", mid, m_owner);
      check("rnd_dsel", dsel, 1 << m_dsel);
      check("rnd_wait", mwait, int'(req & ~2'(1 << m_owner)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
